systolic_mult_ctrl: RTL and testbench
=====================================

// Module: systolic_mult_ctrl
// PURPOSE
//  Sequencer for the bit-serial systolic_multiplier array. Accepts parallel operands on a
//  valid/ready input port, holds the multiplier word stable, and shifts the multiplicand in LSB-first.
//  Deserialises the 2*W-bit product from the array's serial output.
//  Drains stale carries before each new operation, because the array itself has no reset.
//  Returns the product on a valid/ready output port. Sits between the bus-side datapath and one array instance.
// PARAMETERS
//  p_WORD_WIDTH  4   operand width W; product is 2*W bits; must match the array instance
//  p_LATENCY     1   cycles from multiplicand bit 0 driven on o_MULTIPLICAND to product bit 0 sampled on i_MULT_OUT
//  p_FLUSH       8   cycles of all-zero drive used to drain array carries/partials (>= 2*W)
// PORTS
//  i_CLK          in   1     system clock, rising edge
//  i_RST_N        in   1     synchronous reset, active low
//  i_VALID        in   1     operand pair valid
//  o_READY        out  1     controller can accept operands
//  i_OP_A         in   W     multiplicand (serialised LSB-first)
//  i_OP_B         in   W     multiplier (held parallel)
//  o_VALID        out  1     product valid
//  i_READY        in   1     consumer accepts product
//  o_PRODUCT      out  2*W   i_OP_A * i_OP_B, unsigned
//  o_MULTIPLIER   out  W     to array i_MULTIPLIER
//  o_MULTIPLICAND out  1     to array i_MULTIPLICAND
//  i_MULT_OUT     in   1     from array o_OUTPUT
// BEHAVIOUR
//  - States: FLUSH, IDLE, RUN, DONE. One counter r_CNT, width clog2(max(2*W+p_LATENCY, p_FLUSH)+1).
//  - Reset (i_RST_N=0 at an edge, any state):
//    - state<=FLUSH, r_CNT<=0; operand regs <= 0; o_PRODUCT<=0; o_VALID=0; o_READY=0.
//    - A multiply in progress is discarded; the result is never presented.
//  - FLUSH: o_MULTIPLIER=0, o_MULTIPLICAND=0 for p_FLUSH cycles, then IDLE. i_MULT_OUT is ignored.
//  - IDLE: o_READY=1, o_MULTIPLIER=0, o_MULTIPLICAND=0.
//    - On i_VALID&&o_READY: latch A and B, r_CNT<=0, state<=RUN.
//    - i_VALID while not IDLE is not accepted; the source must hold it.
//  - RUN: lasts 2*W+p_LATENCY cycles, r_CNT = 0..2*W+p_LATENCY-1.
//    - o_MULTIPLIER = latched B, stable for the whole RUN.
//    - o_MULTIPLICAND = A[r_CNT] while r_CNT<W, else 0 (zero padding).
//    - When r_CNT>=p_LATENCY: product[r_CNT-p_LATENCY] <= i_MULT_OUT.
//    - Last RUN cycle -> FLUSH with a post-op flag set, r_CNT<=0.
//  - Post-op FLUSH: same drive as FLUSH; exits to DONE instead of IDLE.
//  - DONE: o_VALID=1, o_PRODUCT stable, o_MULTIPLIER=0.
//    - On i_READY: o_VALID<=0, state<=IDLE.
//    - Product is held indefinitely under backpressure.
//  - Timing: accept at edge t -> o_VALID rises at edge t+1+2*W+p_LATENCY+p_FLUSH.
//    - Defaults give t+18. Throughput: one op per 2*W+p_LATENCY+p_FLUSH+2 cycles minimum.
//  - o_READY and o_VALID are registered-state decodes; never asserted together.
//  - o_PRODUCT is updated only in RUN, so it keeps the last result through IDLE.
//  - Arithmetic is unsigned, full width; no overflow is possible in 2*W bits.
//    - Edge operands: 0*X=0, (2^W-1)^2 = 2^(2W) - 2^(W+1) + 1.
//  - i_OP_A and i_OP_B may change freely after acceptance; only latched copies are used.
// TESTING (W=4, p_LATENCY=1, p_FLUSH=8, real systolic_multiplier instance attached)
//  1 Reset low 3 cycles, release -> o_READY=0 for 8 cycles, then 1; o_VALID=0, o_PRODUCT=0 throughout.
//  2 A=3, B=5 accepted at t -> o_VALID=1 at t+18 with o_PRODUCT=0x0F; o_READY=0 from t+1 until IDLE.
//  3 A=15, B=15 -> 0xE1; then A=0, B=9 -> 0x00 (checks carries fully drained between ops).
//  4 Backpressure: A=7, B=6, i_READY low 5 cycles after o_VALID -> 0x2A held stable,
//    o_READY=0 until the cycle after the i_READY handshake.
//  5 Reset mid-RUN (r_CNT=3) during A=9, B=9 -> no o_VALID; after the flush, A=7, B=6 -> 0x2A.
//  6 Random sweep of all 256 operand pairs, back-to-back with i_READY tied 1
//    -> every product matches A*B; o_MULTIPLIER constant during each RUN.

Source files
------------

// File: rtl/systolic_mult_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : systolic_mult_ctrl
// Description : Sequencer for a bit-serial systolic multiplier array.
//               Accepts an operand pair on a valid/ready port, holds the
//               multiplier word, shifts the multiplicand in LSB-first,
//               deserialises the 2*W-bit product and drains the array
//               (which has no reset) with all-zero drive between operations.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_mult_ctrl #(
    parameter int p_WORD_WIDTH = 4,
    parameter int p_LATENCY    = 1,
    parameter int p_FLUSH      = 8
) (
    input  logic                      i_CLK,
    input  logic                      i_RST_N,
    input  logic                      i_VALID,
    output logic                      o_READY,
    input  logic [p_WORD_WIDTH-1:0]   i_OP_A,
    input  logic [p_WORD_WIDTH-1:0]   i_OP_B,
    output logic                      o_VALID,
    input  logic                      i_READY,
    output logic [2*p_WORD_WIDTH-1:0] o_PRODUCT,
    output logic [p_WORD_WIDTH-1:0]   o_MULTIPLIER,
    output logic                      o_MULTIPLICAND,
    input  logic                      i_MULT_OUT
);

    localparam int c_PROD_W  = 2 * p_WORD_WIDTH;
    localparam int c_RUN_LEN = c_PROD_W + p_LATENCY;
    localparam int c_CNT_MAX = (c_RUN_LEN > p_FLUSH) ? c_RUN_LEN : p_FLUSH;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_RUN_LAST   = c_CNT_W'(c_RUN_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_FLUSH_LAST = c_CNT_W'(p_FLUSH - 1);
    localparam logic [c_CNT_W-1:0] c_LAT        = c_CNT_W'(p_LATENCY);
    localparam logic [c_CNT_W-1:0] c_WORD       = c_CNT_W'(p_WORD_WIDTH);

    localparam logic [1:0] c_S_FLUSH = 2'd0;
    localparam logic [1:0] c_S_IDLE  = 2'd1;
    localparam logic [1:0] c_S_RUN   = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [c_CNT_W-1:0]      cnt_q, cnt_d;
    logic                    post_q, post_d;   // flush follows a multiply -> exit to DONE
    logic [p_WORD_WIDTH-1:0] a_q, b_q;
    logic [c_PROD_W-1:0]     prod_q;

    logic [p_WORD_WIDTH-1:0] w_a_shift;
    logic [c_CNT_W-1:0]      w_pidx;
    logic [c_PROD_W-1:0]     w_pmask;

    // State register: sequencing state, shared counter and post-op flag
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q <= c_S_FLUSH;
            cnt_q   <= '0;
            post_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            post_q  <= post_d;
        end
    end

    // Next-state logic: FLUSH -> IDLE -> RUN -> FLUSH(post) -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        post_d  = post_q;
        case (state_q)
            c_S_FLUSH: begin
                if (cnt_q == c_FLUSH_LAST) begin
                    state_d = post_q ? c_S_DONE : c_S_IDLE;
                    cnt_d   = '0;
                    post_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            c_S_IDLE: begin
                if (i_VALID) begin
                    state_d = c_S_RUN;
                    cnt_d   = '0;
                end
            end
            c_S_RUN: begin
                if (cnt_q == c_RUN_LAST) begin
                    state_d = c_S_FLUSH;
                    cnt_d   = '0;
                    post_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            c_S_DONE: begin
                if (i_READY) begin
                    state_d = c_S_IDLE;
                end
            end
            default: begin
                state_d = c_S_FLUSH;
                cnt_d   = '0;
                post_d  = 1'b0;
            end
        endcase
    end

    // Output decode: handshakes and array drive; array sees zeros outside RUN
    always_comb begin
        w_a_shift      = a_q >> cnt_q;
        o_READY        = (state_q == c_S_IDLE);
        o_VALID        = (state_q == c_S_DONE);
        o_MULTIPLIER   = (state_q == c_S_RUN) ? b_q : '0;
        o_MULTIPLICAND = (state_q == c_S_RUN) && (cnt_q < c_WORD) ? w_a_shift[0] : 1'b0;
    end

    // Product bit position for the serial bit arriving this cycle
    always_comb begin
        w_pidx  = cnt_q - c_LAT;
        w_pmask = {{(c_PROD_W-1){1'b0}}, 1'b1} << w_pidx;
    end

    // Datapath: latch operands at acceptance, deserialise product during RUN only
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
        end else begin
            if ((state_q == c_S_IDLE) && i_VALID) begin
                a_q <= i_OP_A;
                b_q <= i_OP_B;
            end
            if ((state_q == c_S_RUN) && (cnt_q >= c_LAT)) begin
                prod_q <= (prod_q & ~w_pmask) | (i_MULT_OUT ? w_pmask : '0);
            end
        end
    end

    assign o_PRODUCT = prod_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_mult_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_systolic_mult_ctrl
// Description : Self-checking bench for systolic_mult_ctrl with a behavioural
//               bit-serial multiplier array attached (no reset, starts with
//               stale carries). Products are checked against plain A*B.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_mult_ctrl;

    localparam int W   = 4;
    localparam int LAT = 1;
    localparam int FL  = 8;
    localparam int PW  = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          valid_o;
    logic          ready_i;
    logic [PW-1:0] prod;
    logic [W-1:0]  mplier;
    logic          mcand;
    logic          mult_out = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    systolic_mult_ctrl #(
        .p_WORD_WIDTH (W),
        .p_LATENCY    (LAT),
        .p_FLUSH      (FL)
    ) dut (
        .i_CLK          (clk),
        .i_RST_N        (rst_n),
        .i_VALID        (valid_i),
        .o_READY        (ready_o),
        .i_OP_A         (op_a),
        .i_OP_B         (op_b),
        .o_VALID        (valid_o),
        .i_READY        (ready_i),
        .o_PRODUCT      (prod),
        .o_MULTIPLIER   (mplier),
        .o_MULTIPLICAND (mcand),
        .i_MULT_OUT     (mult_out)
    );

    // Bit-serial array: partial sum += a_k*B, emit LSB, keep the rest as carry.
    // Starts with garbage so the initial flush has something to drain.
    logic [15:0] arr_acc = 16'h00A5;
    logic [15:0] arr_sum;
    assign arr_sum = arr_acc + (mcand ? {12'd0, mplier} : 16'd0);

    always @(posedge clk) begin
        arr_acc  <= arr_sum >> 1;
        mult_out <= arr_sum[0];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold = cycles of backpressure after o_VALID (0 = i_READY tied high)
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [PW-1:0] exp;
        int n;
        int lat;
        int bad_mult;
        int ready_seen;
        int bad_hold;
        exp     = PW'(int'(a) * int'(b));
        ready_i = (hold == 0);
        op_a    = a;
        op_b    = b;
        valid_i = 1'b1;
        n = 0;
        while (!ready_o && n < 60) begin
            tick();
            n++;
        end
        check("accept_ready", ready_o, 1);
        tick();
        valid_i = 1'b0;
        op_a    = W'($urandom);
        op_b    = W'($urandom);
        lat = 0; bad_mult = 0; ready_seen = 0;
        while (!valid_o && lat < 60) begin
            if (lat < PW + LAT && mplier !== b) bad_mult++;
            if (ready_o) ready_seen++;
            tick();
            lat++;
        end
        // o_VALID visible after edge t+17, i.e. sampled high by the consumer at edge t+18
        check("valid_latency", lat, PW + LAT + FL);
        check("multiplier_stable", bad_mult, 0);
        check("ready_low_busy", ready_seen, 0);
        check("product", prod, exp);
        check("done_ready_low", ready_o, 0);
        if (hold > 0) begin
            bad_hold = 0;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (valid_o !== 1'b1 || prod !== exp || ready_o !== 1'b0 || mplier !== '0) bad_hold++;
            end
            check("backpressure_hold", bad_hold, 0);
            ready_i = 1'b1;
        end
        tick();
        check("handshake_valid_low", valid_o, 0);
        check("handshake_ready_high", ready_o, 1);
        check("product_kept_idle", prod, exp);
    endtask

    initial begin : main
        int perm [256];
        int j;
        int tmp;
        int valid_seen;
        int ready_at;
        logic [7:0] p;

        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        op_a    = '0;
        op_b    = '0;

        // Reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready", ready_o, 0);
            check("rst_valid", valid_o, 0);
            check("rst_product", prod, 0);
        end
        // Release: initial flush keeps o_READY low for 8 cycles
        rst_n = 1'b1;
        for (int i = 1; i <= FL; i++) begin
            tick();
            check("flush_ready", ready_o, (i == FL) ? 1 : 0);
            check("flush_valid", valid_o, 0);
            check("flush_product", prod, 0);
        end

        // Directed operations
        do_op(4'd3, 4'd5, 0);
        do_op(4'd15, 4'd15, 0);
        do_op(4'd0, 4'd9, 0);
        do_op(4'd7, 4'd6, 5);

        // Reset in the middle of RUN (counter at 3)
        ready_i = 1'b0;
        op_a    = 4'd9;
        op_b    = 4'd9;
        valid_i = 1'b1;
        j = 0;
        while (!ready_o && j < 60) begin
            tick();
            j++;
        end
        check("mid_accept_ready", ready_o, 1);
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        tick();
        tick();
        check("mid_rst_product", prod, 0);
        check("mid_rst_valid", valid_o, 0);
        rst_n = 1'b1;
        valid_seen = 0;
        ready_at   = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (valid_o) valid_seen++;
            if (ready_o && ready_at == 0) ready_at = i;
        end
        check("mid_rst_no_valid", valid_seen, 0);
        check("mid_rst_ready_after_flush", ready_at, FL);
        do_op(4'd7, 4'd6, 0);

        // Random-order sweep of all operand pairs, back to back
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            j       = int'($urandom_range(i, 0));
            tmp     = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            p = 8'(perm[i]);
            do_op(p[7:4], p[3:0], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
